gift64_enc_iter: RTL and testbench

Iterative GIFT-64-128 encryption core, one round per clock: it accepts a 64-bit plaintext and a 128-bit key, runs 28 rounds, and returns the ciphertext. It is the encryption counterpart to the decryption datapath, which uses the inverse S-box. It uses the forward GIFT S-box with on-the-fly key schedule and round-constant generation. It sits between the input and output stream stages, with valid/ready handshakes on both sides.

---
 rtl/gift64_enc_iter.sv | 210 +++++++++++++++++++++
 tb/tb_gift64_enc_iter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gift64_enc_iter.sv
// Iterative GIFT-64-128 encryption core: one round per clock, 28 rounds per block,
// valid/ready handshakes on the plaintext/key input and the ciphertext output.

// Forward GIFT S-box applied to every nibble of the 64-bit state.
module gift64_sub_cells (
  input  logic [63:0] state,
  output logic [63:0] sub
);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h1;
      4'h1: y = 4'hA;
      4'h2: y = 4'h4;
      4'h3: y = 4'hC;
      4'h4: y = 4'h6;
      4'h5: y = 4'hF;
      4'h6: y = 4'h3;
      4'h7: y = 4'h9;
      4'h8: y = 4'h2;
      4'h9: y = 4'hD;
      4'hA: y = 4'hB;
      4'hB: y = 4'h7;
      4'hC: y = 4'h5;
      4'hD: y = 4'h0;
      4'hE: y = 4'h8;
      default: y = 4'hE;
    endcase
    return y;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_nibble
      assign sub[4*gi+3:4*gi] = sbox(state[4*gi+3:4*gi]);
    end
  endgenerate

endmodule

// Fixed GIFT-64 bit permutation; pure wiring.
module gift64_perm_bits (
  input  logic [63:0] din,
  output logic [63:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_bit
      localparam int DST = 4 * (gi / 16)
                         + 16 * ((3 * ((gi % 16) / 4) + (gi % 4)) % 4)
                         + (gi % 4);
      assign dout[DST] = din[gi];
    end
  endgenerate

endmodule

// One full round: SubCells, PermBits, AddRoundKey, AddConstant.
module gift64_round (
  input  logic [63:0] state,
  input  logic [31:0] round_key,
  input  logic [5:0]  rc,
  output logic [63:0] next_state
);

  logic [63:0] sub;
  logic [63:0] perm;

  gift64_sub_cells u_sub (
    .state (state),
    .sub   (sub)
  );

  gift64_perm_bits u_perm (
    .din  (sub),
    .dout (perm)
  );

  // round_key = U||V: U lands on bit 1 of each nibble, V on bit 0.
  always_comb begin
    next_state = perm;
    for (int i = 0; i < 16; i++) begin
      next_state[4*i+1] = perm[4*i+1] ^ round_key[16+i];
      next_state[4*i]   = perm[4*i]   ^ round_key[i];
    end
    next_state[63] = perm[63] ^ 1'b1;
    next_state[23] = perm[23] ^ rc[5];
    next_state[19] = perm[19] ^ rc[4];
    next_state[15] = perm[15] ^ rc[3];
    next_state[11] = perm[11] ^ rc[2];
    next_state[7]  = perm[7]  ^ rc[1];
    next_state[3]  = perm[3]  ^ rc[0];
  end

endmodule

// Key schedule step: K <- (k1 >>> 2) || (k0 >>> 12) || k7 .. k2.
module gift64_key_update (
  input  logic [127:0] key,
  output logic [127:0] key_next
);

  logic [15:0] k0;
  logic [15:0] k1;

  assign k0 = key[15:0];
  assign k1 = key[31:16];

  assign key_next = {k1[1:0], k1[15:2], k0[11:0], k0[15:12], key[127:32]};

endmodule

module gift64_enc_iter #(
  parameter int ROUNDS = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inValid,
  output logic         inReady,
  input  logic [63:0]  inData,
  input  logic [127:0] inKey,
  output logic         outValid,
  input  logic         outReady,
  output logic [63:0]  outData
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  logic [1:0]   state_reg;
  logic [1:0]   state_next;
  logic [63:0]  s_reg;
  logic [127:0] key_reg;
  logic [5:0]   rc_reg;
  logic [4:0]   round_reg;

  logic [5:0]   rc_next;
  logic [63:0]  s_next;
  logic [127:0] key_next;
  logic         last_round;

  // The round uses the already-advanced constant.
  assign rc_next    = {rc_reg[4:0], rc_reg[5] ^ rc_reg[4] ^ 1'b1};
  assign last_round = (round_reg == LAST_ROUND);

  gift64_round u_round (
    .state      (s_reg),
    .round_key  (key_reg[31:0]),
    .rc         (rc_next),
    .next_state (s_next)
  );

  gift64_key_update u_key (
    .key      (key_reg),
    .key_next (key_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (inValid) state_next = RUN;
      RUN:  if (last_round) state_next = DONE;
      DONE: if (outReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      s_reg     <= 64'h0;
      key_reg   <= 128'h0;
      rc_reg    <= 6'h00;
      round_reg <= 5'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (inValid) begin
            s_reg     <= inData;
            key_reg   <= inKey;
            rc_reg    <= 6'h00;
            round_reg <= 5'd0;
          end
        end
        RUN: begin
          s_reg   <= s_next;
          key_reg <= key_next;
          rc_reg  <= rc_next;
          // Counter parks on the last round rather than wrapping.
          if (!last_round) begin
            round_reg <= round_reg + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign inReady  = (state_reg == IDLE);
  assign outValid = (state_reg == DONE);
  assign outData  = s_reg;

endmodule

// File: tb/tb_gift64_enc_iter.sv
// Directed bench for gift64_enc_iter: known-answer table, latency, back-pressure,
// back-to-back streaming, reset mid-block and round-constant sequence.
module tb_gift64_enc_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inValid;
  logic         inReady;
  logic [63:0]  inData;
  logic [127:0] inKey;
  logic         outValid;
  logic         outReady;
  logic [63:0]  outData;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [127:0] key;
    logic [63:0]  pt;
    logic [63:0]  ct;
  } vec_t;

  vec_t vecs [3];

  // Constants from rc <- {c4..c0, c5^c4^1}, starting from 0.
  logic [5:0] rc_tab [28] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B
  };

  always #5 clk = ~clk;

  gift64_enc_iter #(.ROUNDS(28)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (inData),
    .inKey    (inKey),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!inReady && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", inReady, 1);
  endtask

  // Accepts one block and waits for outValid; completes the handshake when outReady=1.
  task automatic run_block(input int idx, input string tag);
    int lat = 0;
    wait_in_ready();
    inValid = 1'b1;
    inData  = vecs[idx].pt;
    inKey   = vecs[idx].key;
    @(posedge clk); #1;
    inValid = 1'b0;
    inData  = ~vecs[idx].pt;
    inKey   = ~vecs[idx].key;
    while (!outValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 28);
    chk({tag, "_ct"}, outData, vecs[idx].ct);
    $display("block %s: pt=%h ct=%h latency=%0d", tag, vecs[idx].pt, outData, lat);
    if (outReady) begin
      @(posedge clk); #1;
      chk({tag, "_out_valid_after_hs"}, outValid, 0);
      chk({tag, "_in_ready_after_hs"}, inReady, 1);
    end
  endtask

  initial begin
    int cyc;
    int nxt;
    int t_out[$];
    logic [63:0] d_out[$];

    vecs[0] = '{key: 128'h0, pt: 64'h0, ct: 64'hF62BC3EF34F775AC};
    vecs[1] = '{key: 128'hFEDCBA9876543210FEDCBA9876543210,
                pt:  64'hFEDCBA9876543210, ct: 64'hC1B71F66160FF587};
    vecs[2] = '{key: 128'hBD91731EB6BC2713A1F9F6FFC75044E7,
                pt:  64'hC450C7727A9B8A7D, ct: 64'hE3272885FA94BA8B};

    rst_n    = 1'b0;
    inValid  = 1'b0;
    inData   = 64'h0;
    inKey    = 128'h0;
    outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", inReady, 1);
    chk("reset_out_valid", outValid, 0);
    chk("reset_out_data", outData, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer table
    for (int i = 0; i < 3; i++) begin
      run_block(i, $sformatf("kat%0d", i));
    end

    // Round-constant sequence over one block
    wait_in_ready();
    inValid = 1'b1;
    inData  = vecs[0].pt;
    inKey   = vecs[0].key;
    @(posedge clk); #1;
    inValid = 1'b0;
    chk("rc_load", dut.rc_reg, 6'h00);
    for (int r = 0; r < 28; r++) begin
      @(posedge clk); #1;
      chk($sformatf("rc_round%0d", r + 1), dut.rc_reg, rc_tab[r]);
    end
    chk("rc_block_out_valid", outValid, 1);
    chk("rc_block_ct", outData, vecs[0].ct);
    $display("block rc_probe: ct=%h", outData);
    @(posedge clk); #1;

    // Back-pressure: hold the result for 50 cycles while inValid pulses
    outReady = 1'b0;
    run_block(1, "bp");
    for (int c = 0; c < 50; c++) begin
      inValid = c[0];
      inData  = 64'($urandom());
      inKey   = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      chk($sformatf("bp_out_valid_c%0d", c), outValid, 1);
      chk($sformatf("bp_out_data_c%0d", c), outData, vecs[1].ct);
      chk($sformatf("bp_in_ready_c%0d", c), inReady, 0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", outValid, 0);
    chk("bp_release_in_ready", inReady, 1);
    @(posedge clk); #1;
    chk("bp_idle_in_ready", inReady, 1);
    $display("block bp: released after 50 stalled cycles");

    // Back-to-back: three blocks, inValid and outReady held high
    wait_in_ready();
    cyc     = 0;
    inValid = 1'b1;
    inData  = vecs[0].pt;
    inKey   = vecs[0].key;
    nxt     = 1;
    for (int c = 0; c < 200 && t_out.size() < 3; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (outValid) begin
        t_out.push_back(cyc);
        d_out.push_back(outData);
      end
      if (inReady) begin
        if (nxt < 3) begin
          inData = vecs[nxt].pt;
          inKey  = vecs[nxt].key;
          nxt++;
        end else begin
          inValid = 1'b0;
        end
      end
    end
    inValid = 1'b0;
    chk("b2b_count", t_out.size(), 3);
    for (int i = 0; i < t_out.size(); i++) begin
      chk($sformatf("b2b_ct%0d", i), d_out[i], vecs[i].ct);
      $display("block b2b%0d: ct=%h at cycle %0d", i, d_out[i], t_out[i]);
      if (i > 0) begin
        chk($sformatf("b2b_spacing%0d", i), t_out[i] - t_out[i-1], 30);
      end
    end
    @(posedge clk); #1;
    chk("b2b_final_in_ready", inReady, 1);

    // Reset at round 13 aborts the block
    wait_in_ready();
    inValid = 1'b1;
    inData  = vecs[1].pt;
    inKey   = vecs[1].key;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (13) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", outValid, 0);
    chk("rst_mid_in_ready", inReady, 1);
    chk("rst_mid_out_data", outData, 64'h0);
    chk("rst_mid_rc", dut.rc_reg, 6'h00);
    @(posedge clk); #1;
    chk("rst_hold_out_valid", outValid, 0);
    rst_n = 1'b1;
    $display("block rst_abort: aborted at round 13");
    run_block(2, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
